// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode scan controller: blank/show slots per digit,
// frame-coherent shadow registers, hex decode and leading-zero suppression.
module seg_scan_ctrl #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned FRAME_HZ  = 125,
  parameter int unsigned NUM_DIG   = 8,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic                   CLK_50,
  input  logic                   rst_n,
  input  logic [4*NUM_DIG-1:0]   digit_data,
  input  logic [NUM_DIG-1:0]     dp,
  input  logic [NUM_DIG-1:0]     dig_en,
  input  logic                   lz_sup,
  input  logic                   hold,
  output logic [7:0]             SEL,
  output logic [7:0]             DIG,
  output logic                   frame_start
);

  localparam int unsigned SLOT_CYC = CLK_FREQ / (FRAME_HZ * NUM_DIG);
  localparam int unsigned SHOW_CYC = SLOT_CYC - BLANK_CYC;
  localparam int unsigned CW       = $clog2(SLOT_CYC);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIG - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [4*NUM_DIG-1:0] data_sh_q, data_sh_d;
  logic [NUM_DIG-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIG-1:0]   en_sh_q, en_sh_d;
  logic                 lz_sh_q, lz_sh_d;
  logic [7:0]           sel_q, sel_d;
  logic [7:0]           dig_q, dig_d;
  logic                 fs_q, fs_d;

  logic                 enter_frame;
  logic [NUM_DIG-1:0]   sup;
  logic                 run;
  logic                 dark;
  logic [3:0]           nib;
  int unsigned          di;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot sequencing and frame-boundary shadow capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_sh_d   = data_sh_q;
    dp_sh_d     = dp_sh_q;
    en_sh_d     = en_sh_q;
    lz_sh_d     = lz_sh_q;
    enter_frame = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d     = ST_SHOW;
          cnt_d       = '0;
          enter_frame = (idx_q == 3'd0);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
    if (enter_frame && !hold) begin
      data_sh_d = digit_data;
      dp_sh_d   = dp;
      en_sh_d   = dig_en;
      lz_sh_d   = lz_sup;
    end
    fs_d = enter_frame;
  end

  // Outputs are decoded from next-state values so the registered pins line up with the state
  always_comb begin
    sup = '0;
    run = lz_sh_d;
    di  = 0;
    for (int unsigned k = 0; k < NUM_DIG; k++) begin
      di      = NUM_DIG - 1 - k;
      sup[di] = run && (di != 0) && (data_sh_d[4*di +: 4] == 4'd0) && !dp_sh_d[di];
      run     = run && (sup[di] || !en_sh_d[di]);
    end
    nib   = data_sh_d[{idx_d, 2'b00} +: 4];
    dark  = !en_sh_d[idx_d] || sup[idx_d];
    sel_d = '1;
    dig_d = '1;
    if (state_d == ST_SHOW && !dark) begin
      sel_d = ~(8'd1 << idx_d);
      dig_d = {~dp_sh_d[idx_d], seg7(nib)};
    end
  end

  always_ff @(posedge CLK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_sh_q <= '0;
      dp_sh_q   <= '0;
      en_sh_q   <= '0;
      lz_sh_q   <= 1'b0;
      sel_q     <= '1;
      dig_q     <= '1;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      data_sh_q <= data_sh_d;
      dp_sh_q   <= dp_sh_d;
      en_sh_q   <= en_sh_d;
      lz_sh_q   <= lz_sh_d;
      sel_q     <= sel_d;
      dig_q     <= dig_d;
      fs_q      <= fs_d;
    end
  end

  assign SEL         = sel_q;
  assign DIG         = dig_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus random input changes,
// compared every cycle against a frame-position reference model.
module tb_seg_scan_ctrl;

  localparam int unsigned CLK_FREQ  = 1600;
  localparam int unsigned FRAME_HZ  = 10;
  localparam int unsigned NUM_DIG   = 8;
  localparam int unsigned BLANK_CYC = 4;
  localparam int SLOT  = 20;
  localparam int FRAME = 160;

  logic        CLK_50 = 1'b0;
  logic        rst_n  = 1'b1;
  logic [31:0] digit_data = '0;
  logic [7:0]  dp = '0;
  logic [7:0]  dig_en = '0;
  logic        lz_sup = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  SEL;
  logic [7:0]  DIG;
  logic        frame_start;

  seg_scan_ctrl #(
    .CLK_FREQ (CLK_FREQ),
    .FRAME_HZ (FRAME_HZ),
    .NUM_DIG  (NUM_DIG),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .CLK_50     (CLK_50),
    .rst_n      (rst_n),
    .digit_data (digit_data),
    .dp         (dp),
    .dig_en     (dig_en),
    .lz_sup     (lz_sup),
    .hold       (hold),
    .SEL        (SEL),
    .DIG        (DIG),
    .frame_start(frame_start)
  );

  always #5 CLK_50 = ~CLK_50;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int          n      = 0;

  // reference model: what the display currently holds for this frame
  logic [31:0] m_data = '0;
  logic [7:0]  m_dp   = '0;
  logic [7:0]  m_en   = '0;
  logic        m_lz   = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (pos %0d, t=%0t)", tag, got, exp, n % FRAME, $time);
  endtask

  function automatic void model_out(input int p, output logic [7:0] esel, output logic [7:0] edig);
    int  slot;
    bit  s [8];
    bit  above_ok;
    slot = p / SLOT;
    esel = 8'hFF;
    edig = 8'hFF;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      above_ok = 1'b1;
      for (int j = i + 1; j < NUM_DIG; j++)
        if (!(s[j] || !m_en[j])) above_ok = 1'b0;
      s[i] = m_lz && (i != 0) && (m_data[4*i +: 4] == 4'd0) && !m_dp[i] && above_ok;
    end
    if ((p % SLOT) >= BLANK_CYC && m_en[slot] && !s[slot]) begin
      esel = 8'hFF;
      esel[slot] = 1'b0;
      edig = {~m_dp[slot], seg_tab[m_data[4*slot +: 4]]};
    end
  endfunction

  task automatic tick();
    logic [7:0] es, ed;
    @(posedge CLK_50);
    n++;
    if ((n % FRAME) == BLANK_CYC && !hold) begin
      m_data = digit_data;
      m_dp   = dp;
      m_en   = dig_en;
      m_lz   = lz_sup;
    end
    @(negedge CLK_50);
    model_out(n % FRAME, es, ed);
    check("SEL", SEL, es);
    check("DIG", DIG, ed);
    check("frame_start", {7'd0, frame_start}, {7'd0, (n % FRAME) == BLANK_CYC});
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic run_until(input int target);
    int guard;
    guard = 0;
    while ((n % FRAME) != target) begin
      tick();
      guard++;
      if (guard > FRAME) begin
        check("run_until_timeout", 8'd1, 8'd0);
        break;
      end
    end
  endtask

  // Entered just after a negedge; asynchronous assertion must blank the pins immediately
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_SEL", SEL, 8'hFF);
    check("rst_DIG", DIG, 8'hFF);
    check("rst_fs", {7'd0, frame_start}, 8'd0);
    repeat (2) begin
      @(negedge CLK_50);
      check("rst_SEL_hold", SEL, 8'hFF);
      check("rst_DIG_hold", DIG, 8'hFF);
    end
    rst_n  = 1'b1;
    n      = 0;
    m_data = '0;
    m_dp   = '0;
    m_en   = '0;
    m_lz   = 1'b0;
  endtask

  function automatic logic [31:0] rand_data();
    logic [31:0] d;
    d = '0;
    for (int k = 0; k < 8; k++)
      if ($urandom_range(0, 2) == 0) d[4*k +: 4] = 4'($urandom_range(0, 15));
    return d;
  endfunction

  initial begin
    digit_data = 32'h76543210;
    dig_en     = 8'hFF;
    @(negedge CLK_50);
    do_reset();
    run_cycles(2 * FRAME);

    // data change in the middle of digit 3's slot
    run_until(3 * SLOT + 10);
    digit_data = 32'h0;
    run_cycles(2 * FRAME);

    // leading-zero suppression, then a lit dp breaking the chain
    lz_sup     = 1'b1;
    digit_data = 32'h00000120;
    dp         = 8'h00;
    run_cycles(2 * FRAME);
    dp = 8'h20;
    run_cycles(2 * FRAME);
    dp     = 8'h00;
    lz_sup = 1'b0;

    // disabled upper digits
    dig_en     = 8'h0F;
    digit_data = 32'h89ABCDEF;
    run_cycles(2 * FRAME);

    // hold freezes shadows for three frames
    dig_en = 8'hFF;
    run_cycles(FRAME);
    hold       = 1'b1;
    digit_data = 32'h13579BDF;
    run_cycles(3 * FRAME);
    hold = 1'b0;
    run_cycles(2 * FRAME);

    // reset during SHOW of digit 5
    run_until(5 * SLOT + 10);
    do_reset();
    run_cycles(FRAME + 10);

    // randomized input changes, occasional hold and reset
    for (int it = 0; it < 40; it++) begin
      run_cycles($urandom_range(1, 250));
      digit_data = rand_data();
      dp         = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      dig_en     = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      lz_sup     = 1'($urandom_range(0, 1));
      hold       = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) do_reset();
    end
    hold = 1'b0;
    run_cycles(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one 8-bit segment bus (DIG) between up to eight digit sources on the board's common-anode display.
- Each hex nibble is shown in turn via an active-low digit select (SEL), with a blanking gap between digits to suppress ghosting.
- Sits between the counter/datapath blocks, which supply nibbles, decimal points and enables, and the SEL/DIG pins. It replaces the fixed single-digit SEL tie-off.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- FRAME_HZ, 125, full-frame refresh rate; SLOT_CYC = CLK_FREQ/(FRAME_HZ*NUM_DIG) cycles per digit slot.
- NUM_DIG, 8, digits scanned (1..8).
- BLANK_CYC, 500, blank cycles at the start of each slot; must satisfy 0 < BLANK_CYC < SLOT_CYC. SHOW_CYC = SLOT_CYC - BLANK_CYC.

Ports:
- CLK_50  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- digit_data  in  4*NUM_DIG  hex nibble per digit; digit i = bits [4i+3:4i], digit 0 is the rightmost.
- dp  in  NUM_DIG  decimal point per digit, active high.
- dig_en  in  NUM_DIG  per-digit enable; 0 means the digit stays dark but keeps its slot.
- lz_sup  in  1  leading-zero suppression enable.
- hold  in  1  1 freezes the shadow registers at the frame boundary.
- SEL  out  8  digit select, active low; bits >= NUM_DIG are always 1.
- DIG  out  8  {dp_n, g,f,e,d,c,b,a}, all active low.
- frame_start  out  1  one-cycle pulse on the first SHOW cycle of digit 0.

Behaviour:
- Reset (async assert, sync release): SEL=8'hFF, DIG=8'hFF, frame_start=0, state=BLANK, idx=0, slot counter=0, shadows cleared to 0.
- FSM has two states, BLANK and SHOW, and both SEL and DIG are registered.
  - BLANK: SEL=8'hFF and DIG=8'hFF for exactly BLANK_CYC cycles, then go to SHOW.
  - SHOW: exactly SHOW_CYC cycles, then go to BLANK with idx advanced. idx wraps from NUM_DIG-1 to 0.
- Frame period is exactly NUM_DIG*SLOT_CYC cycles and does not vary with input values.
- Shadow latch:
  - digit_data, dp, dig_en and lz_sup are copied into shadow registers on the edge entering SHOW with idx=0, unless hold=1.
  - The display uses only shadow values, so a frame never tears.
  - frame_start=1 during that same first SHOW cycle, every frame, regardless of hold.
- During SHOW, SEL[idx]=0 and all other bits are 1. DIG[7]=~dp_sh[idx]. DIG[6:0] uses this hex decode:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, B=0000011
  - C=1000110, D=0100001, E=0000110, F=0001110
- Dark digit: if dig_en_sh[idx]=0 or the digit is suppressed, SEL=8'hFF and DIG=8'hFF for the whole slot. Timing is unchanged.
- Leading-zero suppression (lz_sup_sh=1):
  - Digit i is suppressed when its nibble is 0, dp_sh[i]=0, and every digit j>i (j<NUM_DIG) is also suppressed or disabled.
  - Digit 0 is never suppressed.
  - A disabled digit does not break the suppression chain.
- Input changes mid-frame have no visible effect until the next frame boundary.
- Reset mid-slot forces all outputs to 8'hFF immediately (asynchronous). After release, the sequence restarts with a BLANK of BLANK_CYC cycles, then digit 0.
- Clear-at-terminal counters only. The slot counter width is $clog2(SLOT_CYC).

Test Plan (CLK_FREQ=1600, FRAME_HZ=10, NUM_DIG=8, BLANK_CYC=4 → SLOT=20, SHOW=16):
1. Reset, then release with digit_data=32'h76543210, dig_en=8'hFF.
   - 4 cycles of SEL=FF, then SEL=FE with DIG=C0 for 16 cycles, then 4 blank cycles, then SEL=FD with DIG=F9, and so on.
   - frame_start pulses every 160 cycles.
2. Change digit_data to 32'h0 in the middle of digit 3's slot.
   - Digits 3..7 keep their old values until the next frame_start; after that, every digit shows DIG=C0.
3. lz_sup=1, digit_data=32'h00000120, dp=0, dig_en=FF.
   - Digits 7..3 stay dark (SEL=FF); digit 2 shows 1, digit 1 shows 2, digit 0 shows 0.
   - Repeat with dp[5]=1: digit 5 shows DIG=40 ('0' with the dp lit).
4. dig_en=8'h0F: slots 4..7 keep SEL=FF and DIG=FF, and the frame_start period stays 160 cycles.
5. hold=1, then change digit_data: the displayed values stay frozen across 3 frames while frame_start keeps pulsing. Release hold and the new values appear at the next frame.
6. Assert rst_n=0 during SHOW of digit 5: SEL and DIG go to FF within the same cycle. After release, the first lit digit is digit 0, after 4 blank cycles.
